// File: rtl/bit_serial_collector.sv
// Bit-serial collector: assembles LSB-first result bits into a WIDTH-bit word
// and delivers it downstream on a valid/ready handshake.
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   bit_in       - serial result bit
//   bit_valid    - bit_in carries a bit this cycle
//   bit_start    - bit_in is bit 0 of a new frame
//   bit_ready    - a bit can be accepted this cycle
//   word_out     - assembled word, bit i = i-th received bit
//   word_valid   - word_out holds a complete frame
//   word_ready   - downstream takes word_out this cycle
//   busy         - frame in progress
//   frame_err    - one-cycle pulse: bit_start seen mid-frame
//   overrun      - one-cycle pulse: bit offered while not ready
// Optional: define COLLECTOR_FLAGS_EN to add zero_flag / sign_flag outputs.
module bit_serial_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             bit_start,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef COLLECTOR_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             sign_flag
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nx;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nx;
  logic [WIDTH-1:0] w_shift_ins;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] r_word;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_accept;
  logic             w_load;
  logic             w_frame_err_nx;
`ifdef COLLECTOR_FLAGS_EN
  logic             r_zero;
  logic             r_sign;
`endif

  assign bit_ready  = (r_state != S_HOLD) || word_ready;
  assign w_accept   = bit_valid && bit_ready;
  assign word_valid = (r_state == S_HOLD);
  assign busy       = (r_state == S_COLLECT);
  assign word_out   = r_word;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign w_first    = {{(WIDTH-1){1'b0}}, bit_in};
`ifdef COLLECTOR_FLAGS_EN
  assign zero_flag  = r_zero;
  assign sign_flag  = r_sign;
`endif

  // Shift register with the incoming bit dropped in at the current slot.
  always_comb begin
    w_shift_ins          = r_shift;
    w_shift_ins[r_count] = bit_in;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_count_nx     = r_count;
    w_shift_nx     = r_shift;
    w_load         = 1'b0;
    w_frame_err_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && bit_start) begin
          w_state_nx = S_COLLECT;
          w_count_nx = CW'(1);
          w_shift_nx = w_first;
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          if (bit_start) begin
            // Abort: partial frame is discarded, new bit is bit 0.
            w_frame_err_nx = 1'b1;
            w_count_nx     = CW'(1);
            w_shift_nx     = w_first;
          end else if (r_count == CW'(WIDTH-1)) begin
            w_load     = 1'b1;
            w_count_nx = '0;
            w_shift_nx = w_shift_ins;
            w_state_nx = S_HOLD;
          end else begin
            w_count_nx = r_count + 1'b1;
            w_shift_nx = w_shift_ins;
          end
        end
      end
      S_HOLD: begin
        // word_valid is implied in HOLD, so word_ready alone completes it.
        if (word_ready) begin
          if (bit_valid && bit_start) begin
            w_state_nx = S_COLLECT;
            w_count_nx = CW'(1);
            w_shift_nx = w_first;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_word      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef COLLECTOR_FLAGS_EN
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_shift     <= w_shift_nx;
      r_frame_err <= w_frame_err_nx;
      r_overrun   <= bit_valid && !bit_ready;
      if (w_load) begin
        r_word <= w_shift_ins;
`ifdef COLLECTOR_FLAGS_EN
        r_zero <= ~|w_shift_ins;
        r_sign <= w_shift_ins[WIDTH-1];
`endif
      end
    end
  end

endmodule
